// File: rtl/nibble_packer_pkg.sv
// Shared types for the nibble packer: nibble width, nibble type and the
// output-slot state encoding.
package nibble_packer_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nib_t;

  // Output slot: EMPTY has no word to offer, FULL holds a word in out_data.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } opk_state_e;

endpackage : nibble_packer_pkg

// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out bus for nibble_packer.
// Handshake: each side is valid/ready. A beat transfers on a rising clock edge
// where valid and ready are both high. Data and sideband (in_nib/in_last,
// out_data/out_count/out_parity) are only meaningful while valid is high. Once
// out_valid is high it stays high, with out_data/out_count/out_parity stable,
// until the transfer edge. in_ready may depend combinationally on in_valid,
// in_last and out_ready.
// Optional feature macro: NIBBLE_PACKER_PARITY_EN adds out_parity.
interface nibble_packer_if #(
  parameter int NIBBLES = 32
) ();
  import nibble_packer_pkg::*;

  localparam int WORD_W    = NIB_W * NIBBLES;
  localparam int OUT_CNT_W = $clog2(NIBBLES + 1);

  logic                 in_valid;
  logic                 in_ready;
  nib_t                 in_nib;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_data;
  logic [OUT_CNT_W-1:0] out_count;

`ifdef NIBBLE_PACKER_PARITY_EN
  logic                 out_parity;

  // Environment side: nibble producer plus word consumer.
  modport master (
    output in_valid, in_nib, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_parity
  );

  // Packer side.
  modport slave (
    input  in_valid, in_nib, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_parity
  );
`else
  // Environment side: nibble producer plus word consumer.
  modport master (
    output in_valid, in_nib, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // Packer side.
  modport slave (
    input  in_valid, in_nib, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
`endif

endinterface : nibble_packer_if

// File: rtl/nibble_packer_fill.sv
// Fill stage of the nibble packer: owns the partial word (acc) and the fill
// position (cnt), detects the final nibble of a word, and presents the word
// that would be produced if the offered nibble were accepted as final, with
// every nibble above the fill position forced to zero.
module nibble_packer_fill
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             accept,
  input  nib_t                             nib,
  input  logic                             last,
  output logic                             is_final,
  output logic [NIB_W*NIBBLES-1:0]         word,
  output logic [$clog2(NIBBLES+1)-1:0]     word_count
);

  localparam int WORD_W    = NIB_W * NIBBLES;
  localparam int CNT_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int OUT_CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NIBBLES - 1);

  logic [WORD_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  // A nibble closes the word when it fills the top slot or carries in_last.
  assign is_final   = last || (cnt == CNT_MAX);
  assign word_count = OUT_CNT_W'(cnt) + OUT_CNT_W'(1);

  // Accumulate accepted nibbles; a final accept hands the word off and restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (is_final) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc[NIB_W*cnt +: NIB_W] <= nib;
        cnt                     <= cnt + 1'b1;
      end
    end
  end

  // Merge the offered nibble at the fill position and zero everything above it.
  always_comb begin
    word = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (i < int'(cnt)) begin
        word[NIB_W*i +: NIB_W] = acc[NIB_W*i +: NIB_W];
      end else if (i == int'(cnt)) begin
        word[NIB_W*i +: NIB_W] = nib;
      end
    end
  end

endmodule : nibble_packer_fill

// File: rtl/nibble_packer.sv
// nibble_packer: gathers a stream of 4-bit nibbles, LSB-first, into a word of
// NIBBLES nibbles (128 bits by default) and offers it on a valid/ready output.
// A held output word only stalls the input when the offered nibble would
// complete the next word; the old word can leave and the new one load on the
// same edge.
// Optional feature macro: NIBBLE_PACKER_PARITY_EN registers out_parity, the
// XOR of all out_data bits.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  nibble_packer_if.slave    bus,
  output opk_state_e        dbg_state
);

  localparam int WORD_W    = NIB_W * NIBBLES;
  localparam int OUT_CNT_W = $clog2(NIBBLES + 1);

  opk_state_e           state_q;
  opk_state_e           state_d;
  logic                 load;
  logic                 accept;
  logic                 fin_accept;
  logic                 xfer;
  logic                 is_final;
  logic                 out_valid;
  logic                 stall;
  logic [WORD_W-1:0]    fill_word;
  logic [OUT_CNT_W-1:0] fill_count;
  logic [WORD_W-1:0]    data_q;
  logic [OUT_CNT_W-1:0] count_q;

  nibble_packer_fill #(
    .NIBBLES (NIBBLES)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .nib        (bus.in_nib),
    .last       (bus.in_last),
    .is_final   (is_final),
    .word       (fill_word),
    .word_count (fill_count)
  );

  assign out_valid  = (state_q == FULL);
  // Only a final nibble needs the output slot; it waits while the slot is
  // occupied and not draining this cycle.
  assign stall      = out_valid && !bus.out_ready && bus.in_valid && is_final;
  assign bus.in_ready = !rst && !stall;
  assign accept     = bus.in_valid && bus.in_ready;
  assign fin_accept = accept && is_final;
  assign xfer       = out_valid && bus.out_ready;

  // Output slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slot next state: a final accept always loads; a transfer alone empties.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (fin_accept) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (fin_accept) begin
          state_d = FULL;
          load    = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Output word registers, loaded only when a word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= fill_word;
      count_q <= fill_count;
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  logic parity_q;

  // Parity of the loaded word, zero padding included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^fill_word;
    end
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
  assign dbg_state     = state_q;

endmodule : nibble_packer

// File: doc/nibble_packer.md
# nibble_packer

Gathers a stream of 4-bit nibbles into a 128-bit word, nibble 0 in bits [3:0] and nibble 1 in bits [7:4], upward. It is the assembling end of the 128-bit nibble-split interface, which breaks `in[127:0]` into LSB-first nibble lanes. It sits between a nibble-wide producer and a wide-word consumer, with valid/ready on both sides. A held output word does not stall the next word's fill until that fill reaches its final nibble.

## Interface
- `NIBBLES`, default 32: nibbles per word; word width is 4*NIBBLES (128 at default).
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: producer offers `in_nib`.
- `in_ready` output 1: packer accepts `in_nib` this cycle.
- `in_nib` input 4: nibble data.
- `in_last` input 1: nibble closes the word early; qualified by `in_valid`.
- `out_valid` output 1: `out_data` holds a complete word.
- `out_ready` input 1: consumer takes the word.
- `out_data` output 4*NIBBLES: assembled word; unfilled upper nibbles are 0.
- `out_count` output $clog2(NIBBLES+1): nibbles valid in `out_data` (1..NIBBLES).
- `out_parity` output 1: XOR of all `out_data` bits; present only under the configuration macro.

## Operation
- Input accept: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Fill register `acc` and fill counter `cnt` (0..NIBBLES-1). An accepted nibble writes `acc[4*cnt +: 4]`.
- A nibble is final when `cnt == NIBBLES-1` or `in_last` is set. A final accept:
  - loads `out_data` with `acc` including the new nibble, with nibbles above `cnt` forced to 0;
  - loads `out_count` with `cnt+1` and sets `out_valid`;
  - clears `acc` and `cnt`.
- Any other accept increments `cnt`.
- `in_ready` = !rst && !(`out_valid` && !`out_ready` && final-candidate). It drops only when the offered nibble is final and the output slot is occupied and not draining. Non-final nibbles are always accepted.
- Output state machine, two states:
  - EMPTY → FULL on a final accept.
  - FULL → EMPTY on an output transfer without a final accept.
  - FULL → FULL with a new word when an output transfer and a final accept occur in the same cycle.
- `out_data`, `out_count` and `out_parity` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, `out_parity`=0, `cnt`=0, `acc`=0. `in_ready`=0 while `rst` is high.
- Latency: a final nibble accepted at edge N gives `out_valid`=1 from edge N until its transfer edge.
- Throughput: one word per NIBBLES cycles with no bubbles when `out_ready` is held high. A one-nibble word every cycle is sustainable under the same condition.
- Simultaneous final accept and output transfer is not a conflict: the old word leaves and the new word loads at the same edge.
- `in_last` on the nibble at `cnt == NIBBLES-1` is redundant and gives `out_count`=NIBBLES.
- Asserting `rst` mid-fill or mid-hold discards the partial `acc` and the pending word immediately. No spurious `out_valid` follows reset release.

## Configuration
- `NIBBLE_PACKER_PARITY_EN` defined:
  - `out_parity` port exists;
  - it is registered alongside `out_data` and equals the XOR reduction of the loaded word, zero padding included.
- Not defined: no `out_parity` port and no parity logic. All other behaviour is identical.

## Structure
- Shared package `nibble_packer_pkg`:
  - `NIB_W` = 4;
  - a nibble typedef `nib_t`;
  - the output state enum `opk_state_e` {EMPTY, FULL}.
- One sub-module, `nibble_packer_fill`, owns `acc`, `cnt`, final-nibble detection and zero-masking. It presents the masked word and count to the top-level output stage.

## Test plan
- Full word, `out_ready`=1: feed nibbles 0x0..0xF, 0x0..0xF → `out_valid` the cycle after the 32nd accept; `out_data`=128'hFEDCBA98_76543210_FEDCBA98_76543210; `out_count`=32.
- Early close: nibbles 0xA, 0xB, 0xC with `in_last` on 0xC → `out_data`=128'h0...0CBA; `out_count`=3; parity build gives `out_parity`=1.
- Backpressure: `out_ready`=0 with a word held; feed 31 nibbles → all accepted. The 32nd waits with `in_ready`=0. Raise `out_ready` for one cycle → old word transfers and the new word loads on the same edge.
- Back-to-back single nibbles, each with `in_last`, and `out_ready`=1: 0x1, 0x2, 0x3 → three consecutive words with `out_count`=1 and `out_data`=1, 2, 3.
- Reset mid-fill: 10 nibbles in, assert `rst` asynchronously → `out_valid`=0 immediately. After release, a fresh 32-nibble word carries no residue from the discarded nibbles.
